// File: rtl/line_buffer_3row_pkg.sv
// Shared image-pipeline definitions: frame geometry defaults and raster
// position types used by the line buffer and the Sobel window stage.
package line_buffer_3row_pkg;

   // Default pixel format and frame size (RGB888, 480x272 panel).
   localparam int LB_WIDTH_DEF      = 24;
   localparam int LB_PIC_WIDTH_DEF  = 480;
   localparam int LB_PIC_HEIGHT_DEF = 272;

   // Largest legal frame geometry; counter widths cover the full legal range
   // so every legal parameter set fits without per-instance width changes.
   localparam int LB_PIC_WIDTH_MAX  = 511;
   localparam int LB_PIC_HEIGHT_MAX = 1023;

   localparam int COL_W = $clog2(LB_PIC_WIDTH_MAX + 1);   // 9
   localparam int ROW_W = $clog2(LB_PIC_HEIGHT_MAX + 1);  // 10

   // Window rows above the current line needed before output is qualified.
   localparam int WINDOW_ROWS_ABOVE = 2;

   typedef logic [COL_W-1:0] col_t;
   typedef logic [ROW_W-1:0] row_t;

   typedef struct packed {
      row_t row;
      col_t col;
   } pos_t;

   // Advance a raster position by one pixel, wrapping the column at the end of
   // a line and the row at the end of the frame.
   function automatic pos_t pos_advance(input pos_t pos, input int pic_width,
                                        input int pic_height);
      pos_t nxt;
      nxt = pos;
      if (pos.col == col_t'(pic_width - 1)) begin
         nxt.col = '0;
         if (pos.row == row_t'(pic_height - 1)) begin
            nxt.row = '0;
         end else begin
            nxt.row = pos.row + row_t'(1);
         end
      end else begin
         nxt.col = pos.col + col_t'(1);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/line_buffer_3row_line_ram.sv
// One line of pixel storage: synchronous write, asynchronous read. A read at
// the address being written returns the contents from before the edge.
module line_ram
   import line_buffer_3row_pkg::*;
#(
   parameter int DEPTH = LB_PIC_WIDTH_DEF,
   parameter int WIDTH = LB_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             we_i,
   input  col_t             addr_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o
);

   // Storage is deliberately not reset; stale contents are masked upstream.
   logic [WIDTH-1:0] mem_q [DEPTH];

   assign rdata_o = mem_q[addr_i];

   // Write port: store the pixel on the rising edge.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

endmodule

// File: rtl/line_buffer_3row.sv
// Three-row line buffer: presents a vertical column of pixels (lines y-2,
// y-1, y) at the current column for a 3x3 window stage downstream.
module line_buffer_3row
   import line_buffer_3row_pkg::*;
#(
   parameter int WIDTH      = LB_WIDTH_DEF,
   parameter int PIC_WIDTH  = LB_PIC_WIDTH_DEF,
   parameter int PIC_HEIGHT = LB_PIC_HEIGHT_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             frame_start,
   input  logic             valid_in,
   input  logic [WIDTH-1:0] din,
   output logic             valid_out,
   output logic [WIDTH-1:0] dout1,
   output logic [WIDTH-1:0] dout2,
   output logic [WIDTH-1:0] dout3
);

   pos_t             pos_q, pos_d;
   pos_t             pos_cur;
   logic             win_ok;
   logic [WIDTH-1:0] line_a_rd, line_b_rd;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] dout1_q, dout1_d;
   logic [WIDTH-1:0] dout2_q, dout2_d;
   logic [WIDTH-1:0] dout3_q, dout3_d;

   // frame_start retargets a same-cycle pixel to (0,0) before it is used.
   always_comb begin
      pos_cur = pos_q;
      if (frame_start) begin
         pos_cur = '0;
      end
   end

   assign win_ok = (pos_cur.row >= row_t'(WINDOW_ROWS_ABOVE));

   // Line A holds y-2 and is fed from line B; line B holds y-1 and is fed from
   // the incoming pixel. Both shift at the same column on every accepted pixel.
   line_ram #(
      .DEPTH (PIC_WIDTH),
      .WIDTH (WIDTH)
   ) u_line_a (
      .clk     (clk),
      .we_i    (valid_in),
      .addr_i  (pos_cur.col),
      .wdata_i (line_b_rd),
      .rdata_o (line_a_rd)
   );

   line_ram #(
      .DEPTH (PIC_WIDTH),
      .WIDTH (WIDTH)
   ) u_line_b (
      .clk     (clk),
      .we_i    (valid_in),
      .addr_i  (pos_cur.col),
      .wdata_i (din),
      .rdata_o (line_b_rd)
   );

   // Next position and window outputs; everything holds while valid_in is low.
   always_comb begin
      pos_d   = pos_cur;
      valid_d = 1'b0;
      dout1_d = dout1_q;
      dout2_d = dout2_q;
      dout3_d = dout3_q;
      if (valid_in) begin
         pos_d   = pos_advance(pos_cur, PIC_WIDTH, PIC_HEIGHT);
         valid_d = win_ok;
         dout1_d = line_a_rd;
         dout2_d = line_b_rd;
         dout3_d = din;
      end
   end

   // Raster position counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos_q <= '0;
      end else begin
         pos_q <= pos_d;
      end
   end

   // Registered window column and its qualifier.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         dout1_q <= '0;
         dout2_q <= '0;
         dout3_q <= '0;
      end else begin
         valid_q <= valid_d;
         dout1_q <= dout1_d;
         dout2_q <= dout2_d;
         dout3_q <= dout3_d;
      end
   end

   assign valid_out = valid_q;
   assign dout1     = dout1_q;
   assign dout2     = dout2_q;
   assign dout3     = dout3_q;

endmodule

// File: tb/tb_line_buffer_3row.sv
module tb_line_buffer_3row;

   localparam int W  = 24;
   localparam int PW = 4;
   localparam int PH = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         frame_start = 1'b0;
   logic         valid_in = 1'b0;
   logic [W-1:0] din = '0;
   logic         valid_out;
   logic [W-1:0] dout1, dout2, dout3;

   line_buffer_3row #(
      .WIDTH      (W),
      .PIC_WIDTH  (PW),
      .PIC_HEIGHT (PH)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .valid_in    (valid_in),
      .din         (din),
      .valid_out   (valid_out),
      .dout1       (dout1),
      .dout2       (dout2),
      .dout3       (dout3)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: the current frame as a 2-D image in raster coordinates.
   // A qualified output at (r,c) shows img[r-2][c], img[r-1][c] and the pixel.
   logic [W-1:0] img [PH][PW];
   int           m_row = 0;
   int           m_col = 0;
   logic [W-1:0] exp_d1 = '0, exp_d2 = '0, exp_d3 = '0;
   logic         exp_v = 1'b0;
   bit           known12 = 1'b1;
   int           frame_valids = 0;

   task automatic chk(input string tag, input logic [W-1:0] obs,
                      input logic [W-1:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic logic [W-1:0] pix(input int r, input int c);
      return W'(r * 16 + c);
   endfunction

   task automatic model_reset();
      m_row = 0; m_col = 0;
      exp_d1 = '0; exp_d2 = '0; exp_d3 = '0; exp_v = 1'b0; known12 = 1'b1;
   endtask

   task automatic step(input bit fs, input bit v, input logic [W-1:0] d);
      @(negedge clk);
      frame_start = fs; valid_in = v; din = d;
      @(posedge clk);
      #1;
      if (fs) begin
         m_row = 0; m_col = 0;
      end
      if (v) begin
         exp_v  = (m_row >= 2);
         exp_d3 = d;
         if (exp_v) begin
            exp_d1 = img[m_row-2][m_col];
            exp_d2 = img[m_row-1][m_col];
            known12 = 1'b1;
         end else begin
            known12 = 1'b0;
         end
         img[m_row][m_col] = d;
         m_col++;
         if (m_col == PW) begin
            m_col = 0;
            m_row = (m_row + 1) % PH;
         end
      end else begin
         exp_v = 1'b0;
      end
      chk("valid_out", W'(valid_out), W'(exp_v));
      chk("dout3", dout3, exp_d3);
      if (known12) begin
         chk("dout2", dout2, exp_d2);
         chk("dout1", dout1, exp_d1);
      end
      if (valid_out) frame_valids++;
   endtask

   // One frame of row*16+col pixels, optionally with an idle cycle after each.
   task automatic frame_pattern(input bit gaps);
      frame_valids = 0;
      for (int r = 0; r < PH; r++) begin
         for (int c = 0; c < PW; c++) begin
            step(1'b0, 1'b1, pix(r, c));
            if (r == 2 && c == 0) begin
               chk("first_win_d1", dout1, 24'h00);
               chk("first_win_d2", dout2, 24'h10);
               chk("first_win_d3", dout3, 24'h20);
               chk("first_win_v", W'(valid_out), W'(1));
            end
            if (r == 2 && c == 3) begin
               chk("colwrap_d1", dout1, 24'h03);
               chk("colwrap_d2", dout2, 24'h13);
               chk("colwrap_d3", dout3, 24'h23);
            end
            if (r == 3 && c == 0) begin
               chk("rowwrap_d1", dout1, 24'h10);
               chk("rowwrap_d2", dout2, 24'h20);
               chk("rowwrap_d3", dout3, 24'h30);
            end
            if (gaps) begin
               step(1'b0, 1'b0, W'($urandom));
               chk("gap_valid", W'(valid_out), W'(0));
            end
         end
      end
      chk("valids_per_frame", W'(frame_valids), W'(8));
   endtask

   initial begin
      // Reset asserted: outputs forced to zero even with active inputs.
      #2 rst_n = 1'b0;
      #1;
      chk("rst_valid", W'(valid_out), W'(0));
      chk("rst_dout1", dout1, '0);
      chk("rst_dout2", dout2, '0);
      chk("rst_dout3", dout3, '0);
      valid_in = 1'b1; din = 24'hABCDEF;
      @(posedge clk); #1;
      chk("rst_hold_dout3", dout3, '0);
      valid_in = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      // Continuous frame, then a second one exercising the frame wrap.
      frame_pattern(1'b0);
      frame_pattern(1'b0);
      // Pixels arriving every other cycle.
      frame_pattern(1'b1);

      // frame_start arriving with what would have been pixel (3,1).
      for (int i = 0; i < 13; i++) step(1'b0, 1'b1, pix(i / PW, i % PW));
      step(1'b1, 1'b1, pix(3, 1));
      chk("fs_pixel_valid", W'(valid_out), W'(0));
      for (int i = 0; i < 7; i++) step(1'b0, 1'b1, W'($urandom));
      step(1'b0, 1'b1, W'($urandom));
      chk("fs_ninth_valid", W'(valid_out), W'(1));

      // Realign with a bare frame_start, go mid-line, then reset asynchronously.
      step(1'b1, 1'b0, '0);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, pix(i / PW, i % PW));
      @(negedge clk);
      valid_in = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", W'(valid_out), W'(0));
      chk("async_rst_dout1", dout1, '0);
      chk("async_rst_dout2", dout2, '0);
      chk("async_rst_dout3", dout3, '0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      frame_pattern(1'b0);

      // Randomised traffic with sporadic frame restarts.
      for (int i = 0; i < 400; i++) begin
         step(($urandom % 37) == 0, ($urandom % 4) != 0, W'($urandom));
      end

      @(negedge clk);
      valid_in = 1'b0; frame_start = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
